// File: rtl/iter_mul.sv
// Iterative radix-2 shift-add multiplier for the M-extension multiply ops (mul/mulh/mulhsu/mulhu).
// Works on operand magnitudes, then applies the result sign on the final accumulation edge.
module iter_mul #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   MulSel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] MulRes,
    output logic         busy
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [2*N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [N-1:0]    res_q, res_d;
    logic            neg_q, neg_d;
    logic            high_q, high_d;

    logic            a_neg, b_neg;
    logic [N-1:0]    a_mag, b_mag;
    logic [2*N-1:0]  sum, prod;

    // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
    always_comb begin
        a_neg = (MulSel != 2'b11) && A[N-1];
        b_neg = !MulSel[1] && B[N-1];
        a_mag = a_neg ? (N'(0) - A) : A;
        b_mag = b_neg ? (N'(0) - B) : B;
        sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod  = neg_q ? ((2*N)'(0) - sum) : sum;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        res_d     = res_q;
        neg_d     = neg_q;
        high_d    = high_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{N{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                    high_d   = (MulSel != 2'b00);
                end
            end
            StCalc: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    res_d   = high_q ? prod[2*N-1:N] : prod[N-1:0];
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            res_q    <= '0;
            neg_q    <= 1'b0;
            high_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            res_q    <= res_d;
            neg_q    <= neg_d;
            high_q   <= high_d;
        end
    end

    assign MulRes = res_q;

endmodule

// File: tb/tb_iter_mul.sv
// Directed bench for iter_mul: reset, signed/unsigned corners, backpressure, abort and
// back-to-back streaming against a 64-bit reference product.
module tb_iter_mul;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [1:0]   MulSel = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] MulRes;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    iter_mul #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .MulSel    (MulSel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .MulRes    (MulRes),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] sel);
        logic [63:0] ea, eb, p;
        ea = (sel != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb = (!sel[1] && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p  = ea * eb;
        return (sel == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Waits (bounded) for in_ready, presents one operation, returns #1 after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        A = a;
        B = b;
        MulSel = sel;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        MulSel = 2'($urandom);
    endtask

    // lat = edges after the accepting edge until out_valid is seen (capped at 100).
    task automatic wait_result(output logic [31:0] res, output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = MulRes;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        A = 32'd9;
        B = 32'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        checks++;
        if (MulRes !== 32'h0) begin
            errors++;
            $display("FAIL reset_res: MulRes=%h, required 00000000", MulRes);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_mul_basic();
        logic [31:0] res;
        int lat;
        start_op(32'd7, 32'hFFFF_FFFD, 2'b00);
        wait_result(res, lat);
        checks++;
        if (res !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_7x-3: MulRes=%h, required ffffffeb", res);
        end
        // 33 edges counting the accepting one: accept + 32 accumulation edges.
        checks++;
        if (lat + 1 !== 33) begin
            errors++;
            $display("FAIL mul_latency: edges=%0d, required 33", lat + 1);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_flags: in_ready=%b busy=%b, required 0 1", in_ready, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || MulRes !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL drain_idle: in_ready=%b out_valid=%b MulRes=%h, required 1 0 ffffffeb",
                     in_ready, out_valid, MulRes);
        end
    endtask

    task automatic test_corners();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [1:0]  vs [10];
        logic [31:0] ve [10];
        logic [31:0] res;
        int lat;
        va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; vs[0] = 2'b01; ve[0] = 32'h4000_0000;
        va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vs[1] = 2'b11; ve[1] = 32'h4000_0000;
        va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vs[2] = 2'b00; ve[2] = 32'h0000_0000;
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vs[3] = 2'b10; ve[3] = 32'hFFFF_FFFF;
        va[4] = 32'hFFFF_FFFF; vb[4] = 32'hFFFF_FFFF; vs[4] = 2'b11; ve[4] = 32'hFFFF_FFFE;
        va[5] = 32'hFFFF_FFFF; vb[5] = 32'hFFFF_FFFF; vs[5] = 2'b01; ve[5] = 32'h0000_0000;
        va[6] = 32'hFFFF_FFFF; vb[6] = 32'hFFFF_FFFF; vs[6] = 2'b00; ve[6] = 32'h0000_0001;
        va[7] = 32'h7FFF_FFFF; vb[7] = 32'h7FFF_FFFF; vs[7] = 2'b01; ve[7] = 32'h3FFF_FFFF;
        va[8] = 32'h0000_0000; vb[8] = 32'h1234_5678; vs[8] = 2'b11; ve[8] = 32'h0000_0000;
        va[9] = 32'h1234_5678; vb[9] = 32'h0000_0000; vs[9] = 2'b00; ve[9] = 32'h0000_0000;
        for (int i = 0; i < 10; i++) begin
            start_op(va[i], vb[i], vs[i]);
            wait_result(res, lat);
            checks++;
            if (res !== ve[i] || lat !== 32) begin
                errors++;
                $display("FAIL corner_%0d: MulRes=%h lat=%0d, required %h lat=32",
                         i, res, lat, ve[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int lat;
        out_ready = 1'b0;
        start_op(32'h0001_0001, 32'h0001_0001, 2'b00);
        wait_result(res, lat);
        for (int i = 0; i < 5; i++) begin
            A = $urandom;
            B = $urandom;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || MulRes !== 32'h0002_0001 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_%0d: out_valid=%b MulRes=%h in_ready=%b, required 1 00020001 0",
                         i, out_valid, MulRes, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: busy=%b in_ready=%b out_valid=%b, required 0 1 0",
                     busy, in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int lat;
        start_op(32'h0000_FFFF, 32'h0000_FFFF, 2'b00);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
                     out_valid, busy, in_ready);
        end
        start_op(32'd3, 32'd5, 2'b00);
        wait_result(res, lat);
        checks++;
        if (res !== 32'h0000_000F || lat !== 32) begin
            errors++;
            $display("FAIL abort_rerun: MulRes=%h lat=%0d, required 0000000f lat=32", res, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        logic [31:0] exp_res;
        int acc_cyc, prev_cyc, n, lat;
        logic [31:0] res;
        for (int i = 0; i < 8; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        prev_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            A = ta[i];
            B = tb[i];
            MulSel = 2'(i);
            @(posedge clk); #1;
            acc_cyc = cyc;
            wait_result(res, lat);
            exp_res = ref_mul(ta[i], tb[i], 2'(i));
            checks++;
            if (res !== exp_res) begin
                errors++;
                $display("FAIL b2b_result_%0d: MulRes=%h, required %h", i, res, exp_res);
            end
            if (i > 0) begin
                checks++;
                if (acc_cyc - prev_cyc !== N + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: gap=%0d, required %0d",
                             i, acc_cyc - prev_cyc, N + 2);
                end
            end
            prev_cyc = acc_cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_corners();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
